mac_operand_sequencer: RTL and testbench

Initiator-side controller for one mac_unit. It accepts a dot-product job (length plus a stream of data/weight pairs over valid/ready) and drives the MAC's enable_mac, clear_accum, data_in and weight_in ports. When the last product has been accumulated, it captures the 32-bit S15.16 accumulator and requantizes it to S5.10 with round-half-up and saturation. It then presents the result on a valid/ready output port. It sits between the operand buffers and the MAC, and is the template for per-column drivers of the systolic array.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/requant_sat.sv | 39 +++
 rtl/mac_operand_sequencer.sv | 130 +++++++++++++
 tb/tb_mac_operand_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, fixed-point fraction positions and sequencer state encoding for the MAC datapath.
// Requant shift is derived from the accumulator and data fraction positions so they stay consistent.
package mac_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_ACCUM_WIDTH  = 32;
    localparam int DEF_LEN_WIDTH    = 8;

    localparam int DATA_FRAC   = 10;
    localparam int WEIGHT_FRAC = 6;
    localparam int ACCUM_FRAC  = 16;
    localparam int FRAC_SHIFT  = ACCUM_FRAC - DATA_FRAC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/requant_sat.sv
// Combinational S15.16 -> S5.10 requantizer: round-half-up, arithmetic shift, saturate. Zero latency, no flow control.
// One guard bit above the accumulator keeps the rounding add from overflowing.
module requant_sat #(
    parameter int DATA_WIDTH  = mac_pkg::DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = mac_pkg::DEF_ACCUM_WIDTH,
    parameter int FRAC_SHIFT  = mac_pkg::FRAC_SHIFT
) (
    input  logic [ACCUM_WIDTH-1:0] accum_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   sat_o
);

    localparam logic signed [ACCUM_WIDTH:0] RND_K =
        {{(ACCUM_WIDTH+1-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [ACCUM_WIDTH:0] MAX_V =
        {{(ACCUM_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH:0] MIN_V =
        {{(ACCUM_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACCUM_WIDTH:0] ext;
    logic signed [ACCUM_WIDTH:0] rounded;
    logic signed [ACCUM_WIDTH:0] shifted;

    always_comb begin
        ext     = {accum_i[ACCUM_WIDTH-1], accum_i};
        rounded = ext + RND_K;
        shifted = rounded >>> FRAC_SHIFT;
        data_o  = shifted[DATA_WIDTH-1:0];
        sat_o   = 1'b0;
        if (shifted > MAX_V) begin
            data_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            sat_o  = 1'b1;
        end else if (shifted < MIN_V) begin
            data_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds one dot-product job into a mac_unit and returns the requantized result; res_valid rises 2 edges after the last accept.
// Operands stall via in_ready (high only in FEED); the result is held until res_ready, and new jobs wait until then.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
    parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
    parameter int SHIFT        = FRAC_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    vec_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    output logic                    mac_enable,
    output logic                    mac_clear,
    output logic [DATA_WIDTH-1:0]   mac_data,
    output logic [WEIGHT_WIDTH-1:0] mac_weight,
    input  logic [ACCUM_WIDTH-1:0]  accum_in,
    input  logic                    accum_valid_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_sat
);

    seq_state_e              state_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic                    mac_enable_q;
    logic                    mac_clear_q;
    logic [DATA_WIDTH-1:0]   mac_data_q;
    logic [WEIGHT_WIDTH-1:0] mac_weight_q;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic                    res_sat_q;

    logic                    accept;
    logic                    last_op;
    logic [DATA_WIDTH-1:0]   rq_data;
    logic                    rq_sat;

    requant_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .FRAC_SHIFT  (SHIFT)
    ) u_requant (
        .accum_i (accum_in),
        .data_o  (rq_data),
        .sat_o   (rq_sat)
    );

    assign accept  = in_valid && (state_q == ST_FEED);
    assign last_op = (cnt_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            mac_enable_q <= 1'b0;
            mac_clear_q  <= 1'b0;
            mac_data_q   <= '0;
            mac_weight_q <= '0;
            res_data_q   <= '0;
            res_sat_q    <= 1'b0;
        end else begin
            mac_enable_q <= 1'b0;
            mac_clear_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (vec_len != '0) begin
                            len_q   <= vec_len;
                            cnt_q   <= '0;
                            state_q <= ST_FEED;
                        end else begin
                            // Empty job: zero result without touching the MAC.
                            res_data_q <= '0;
                            res_sat_q  <= 1'b0;
                            state_q    <= ST_OUT;
                        end
                    end
                end
                ST_FEED: begin
                    if (accept) begin
                        mac_enable_q <= 1'b1;
                        mac_clear_q  <= (cnt_q == '0);
                        mac_data_q   <= in_data;
                        mac_weight_q <= in_weight;
                        cnt_q        <= cnt_q + LEN_WIDTH'(1);
                        if (last_op) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // The MAC's valid is only trustworthy once our own enable has dropped.
                    if (!mac_enable_q && accum_valid_in) begin
                        res_data_q <= rq_data;
                        res_sat_q  <= rq_sat;
                        state_q    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign in_ready   = (state_q == ST_FEED);
    assign res_valid  = (state_q == ST_OUT);
    assign mac_enable = mac_enable_q;
    assign mac_clear  = mac_clear_q;
    assign mac_data   = mac_data_q;
    assign mac_weight = mac_weight_q;
    assign res_data   = res_data_q;
    assign res_sat    = res_sat_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer with a behavioural mac_unit attached; results are checked against
// a sum-of-products reference with round-half-up and saturation.
module tb_mac_operand_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_weight;
    logic        mac_enable;
    logic        mac_clear;
    logic [15:0] mac_data;
    logic [7:0]  mac_weight;
    logic [31:0] accum_in;
    logic        accum_valid_in;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_sat;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] jd [256];
    logic [7:0]  jw [256];
    int          vpat[$];
    int          bubble_pct = 0;

    int en_cnt  = 0;
    int clr_cnt = 0;
    int bad_clr = 0;

    mac_operand_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vec_len        (vec_len),
        .busy           (busy),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_weight      (in_weight),
        .mac_enable     (mac_enable),
        .mac_clear      (mac_clear),
        .mac_data       (mac_data),
        .mac_weight     (mac_weight),
        .accum_in       (accum_in),
        .accum_valid_in (accum_valid_in),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_sat        (res_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mac_unit: accumulates on enable edges, valid the cycle after.
    always @(posedge clk) begin
        if (!rst_n) begin
            accum_in       <= '0;
            accum_valid_in <= 1'b0;
        end else begin
            accum_valid_in <= mac_enable;
            if (mac_enable) begin
                if (mac_clear)
                    accum_in <= 32'(int'($signed(mac_data)) * int'($signed(mac_weight)));
                else
                    accum_in <= accum_in + 32'(int'($signed(mac_data)) * int'($signed(mac_weight)));
            end
        end
    end

    always @(posedge clk) begin
        if (mac_clear && !(mac_enable && en_cnt == 0)) bad_clr++;
        if (mac_clear) clr_cnt++;
        if (mac_enable) en_cnt++;
    end

    function automatic void ref_result(input int len, output logic [15:0] ed, output logic es);
        longint s;
        longint t;
        s = 0;
        for (int i = 0; i < len; i++)
            s += longint'($signed(jd[i])) * longint'($signed(jw[i]));
        t = (s + 64'sd32) >>> 6;
        if (t > 32767) begin
            ed = 16'h7FFF; es = 1'b1;
        end else if (t < -32768) begin
            ed = 16'h8000; es = 1'b1;
        end else begin
            ed = t[15:0]; es = 1'b0;
        end
    endfunction

    task automatic do_job(input int len, input bit drain,
                          output logic [15:0] rd, output logic rs, output int lat,
                          output logic post_valid, output logic post_busy);
        int   idx;
        int   guard;
        logic acc;
        en_cnt  = 0;
        clr_cnt = 0;
        bad_clr = 0;
        vec_len = 8'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        vec_len = 8'($urandom);
        idx = 0;
        guard = 0;
        while (idx < len && guard < 3000) begin
            if (vpat.size() > 0) in_valid = (vpat.pop_front() != 0);
            else                 in_valid = ($urandom_range(99) >= bubble_pct);
            in_data   = in_valid ? jd[idx] : 16'($urandom);
            in_weight = in_valid ? jw[idx] : 8'($urandom);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = res_data;
        rs = res_sat;
        post_valid = res_valid;
        post_busy  = busy;
        if (drain) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready  = 1'b0;
            post_valid = res_valid;
            post_busy  = busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, in_ready, mac_enable, mac_clear, mac_data, mac_weight, res_valid, res_data, res_sat} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b en=%b clr=%b md=%h mw=%h rv=%b rd=%h rs=%b, want all 0",
                     busy, in_ready, mac_enable, mac_clear, mac_data, mac_weight, res_valid, res_data, res_sat);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] rd, ed;
        logic        rs, es, pv, pb;
        int          lat;
        for (int i = 0; i < 4; i++) begin jd[i] = 16'h0400; jw[i] = 8'h40; end
        vpat = '{1, 1, 1, 1};
        do_job(4, 1'b1, rd, rs, lat, pv, pb);
        ref_result(4, ed, es);
        n_cmp++; if (rd !== 16'h1000 || rd !== ed) begin n_err++; $display("FAIL basic_data: got %h want %h", rd, ed); end
        n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", rs); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
        n_cmp++; if (clr_cnt !== 1 || bad_clr !== 0) begin n_err++; $display("FAIL basic_clear: got %0d clears (%0d misplaced) want 1 with first pair", clr_cnt, bad_clr); end
        n_cmp++; if (en_cnt !== 4) begin n_err++; $display("FAIL basic_enables: got %0d want 4", en_cnt); end
        n_cmp++; if (pv !== 1'b0 || pb !== 1'b0) begin n_err++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", pv, pb); end
    endtask

    task automatic test_bubbles();
        logic [15:0] rd, ed;
        logic        rs, es, pv, pb;
        int          lat;
        jd[0] = 16'h0800; jw[0] = 8'h40;
        jd[1] = 16'hFC00; jw[1] = 8'h40;
        jd[2] = 16'h0400; jw[2] = 8'h20;
        vpat = '{1, 0, 0, 1, 0, 1};
        do_job(3, 1'b1, rd, rs, lat, pv, pb);
        ref_result(3, ed, es);
        n_cmp++; if (rd !== ed || rs !== es) begin n_err++; $display("FAIL bubble_result: got %h/%b want %h/%b", rd, rs, ed, es); end
        n_cmp++; if (en_cnt !== 3 || clr_cnt !== 1 || bad_clr !== 0) begin n_err++; $display("FAIL bubble_enables: got en=%0d clr=%0d bad=%0d want 3 1 0", en_cnt, clr_cnt, bad_clr); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL bubble_latency: got %0d want 2", lat); end
    endtask

    task automatic test_rounding();
        logic [15:0] rd, ed;
        logic        rs, es, pv, pb;
        int          lat;
        logic [15:0] din  [3];
        logic [15:0] want [3];
        din  = '{16'hFFE0, 16'hFFDF, 16'h0020};
        want = '{16'h0000, 16'hFFFF, 16'h0001};
        for (int k = 0; k < 3; k++) begin
            jd[0] = din[k]; jw[0] = 8'h01;
            do_job(1, 1'b1, rd, rs, lat, pv, pb);
            ref_result(1, ed, es);
            n_cmp++;
            if (rd !== want[k] || rd !== ed || rs !== 1'b0) begin
                n_err++;
                $display("FAIL round_%0d: got %h/%b want %h/0", k, rd, rs, want[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] rd;
        logic        rs, pv, pb;
        int          lat;
        for (int i = 0; i < 8; i++) begin jd[i] = 16'h7FFF; jw[i] = 8'h7F; end
        do_job(8, 1'b1, rd, rs, lat, pv, pb);
        n_cmp++; if (rd !== 16'h7FFF || rs !== 1'b1) begin n_err++; $display("FAIL sat_pos: got %h/%b want 7fff/1", rd, rs); end
        for (int i = 0; i < 8; i++) begin jd[i] = 16'h8000; jw[i] = 8'h7F; end
        do_job(8, 1'b1, rd, rs, lat, pv, pb);
        n_cmp++; if (rd !== 16'h8000 || rs !== 1'b1) begin n_err++; $display("FAIL sat_neg: got %h/%b want 8000/1", rd, rs); end
    endtask

    task automatic test_backpressure();
        logic [15:0] rd;
        logic        rs, pv, pb;
        int          lat;
        jd[0] = 16'h0400; jw[0] = 8'h40;
        jd[1] = 16'h0C00; jw[1] = 8'hE0;
        do_job(2, 1'b0, rd, rs, lat, pv, pb);
        for (int c = 0; c < 5; c++) begin
            start    = 1'($urandom);
            vec_len  = 8'($urandom_range(1, 9));
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== rd || res_sat !== rs || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got rv=%b rd=%h rs=%b rdy=%b busy=%b want 1 %h %b 0 1",
                         c, res_valid, res_data, res_sat, in_ready, busy, rd, rs);
            end
        end
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release: got rv=%b busy=%b want 0 0", res_valid, busy); end

        do_job(0, 1'b0, rd, rs, lat, pv, pb);
        n_cmp++; if (lat !== 0 || rd !== 16'h0000 || rs !== 1'b0 || en_cnt !== 0) begin n_err++; $display("FAIL zero_len: got lat=%0d rd=%h rs=%b en=%0d want 0 0000 0 0", lat, rd, rs, en_cnt); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_len_drain: got rv=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_reset_mid_job();
        logic [15:0] rd, ed;
        logic        rs, es, pv, pb;
        int          lat;
        vec_len = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'($urandom); in_weight = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, in_ready, mac_enable, mac_clear, mac_data, mac_weight, res_valid, res_data, res_sat} !== '0) begin
            n_err++;
            $display("FAIL midjob_reset: got busy=%b en=%b clr=%b md=%h mw=%h rv=%b rd=%h want all 0",
                     busy, mac_enable, mac_clear, mac_data, mac_weight, res_valid, res_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        jd[0] = 16'h0A00; jw[0] = 8'hC0;
        do_job(1, 1'b1, rd, rs, lat, pv, pb);
        ref_result(1, ed, es);
        n_cmp++; if (clr_cnt !== 1 || bad_clr !== 0) begin n_err++; $display("FAIL midjob_clear: got %0d clears (%0d misplaced) want 1", clr_cnt, bad_clr); end
        n_cmp++; if (rd !== ed || rs !== es) begin n_err++; $display("FAIL midjob_result: got %h/%b want %h/%b", rd, rs, ed, es); end
    endtask

    task automatic test_random_jobs();
        logic [15:0] rd, ed;
        logic        rs, es, pv, pb;
        int          lat, len;
        bubble_pct = 30;
        for (int j = 0; j < 24; j++) begin
            if (j == 0)       len = 255;
            else if (j == 1)  len = 0;
            else              len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                jd[i] = 16'($urandom);
                jw[i] = 8'($urandom);
            end
            if (j % 5 == 2)
                for (int i = 0; i < len; i++) begin jd[i] = 16'h8000 | 16'($urandom_range(0, 15)); jw[i] = 8'h80; end
            do_job(len, 1'b1, rd, rs, lat, pv, pb);
            ref_result(len, ed, es);
            n_cmp++;
            if (rd !== ed || rs !== es || lat !== ((len == 0) ? 0 : 2) || en_cnt !== len ||
                clr_cnt !== ((len == 0) ? 0 : 1) || bad_clr !== 0 || pv !== 1'b0) begin
                n_err++;
                $display("FAIL random_%0d: len=%0d got %h/%b lat=%0d en=%0d clr=%0d bad=%0d want %h/%b",
                         j, len, rd, rs, lat, en_cnt, clr_cnt, bad_clr, ed, es);
            end
        end
        bubble_pct = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid_job();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
